// File: rtl/proposal_sram_pkg.sv
// Shared constants, clear-FSM state type and byte-mask expansion for the proposal SRAM.
package proposal_sram_pkg;

  localparam int BW_DEF         = 8;
  localparam int Q_DEF          = 16;
  localparam int ADDR_SPACE_DEF = 4;

  // Upper bounds for the mask expansion helper; instances must stay within them.
  localparam int MAX_BW = 32;
  localparam int MAX_Q  = 64;
  localparam int MAX_W  = MAX_BW * MAX_Q;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  function automatic logic [MAX_W-1:0] expand_mask(input logic [MAX_Q-1:0] mask, input int bw);
    logic [MAX_W-1:0] bits;
    bits = '0;
    for (int i = 0; i < MAX_Q; i++) begin
      for (int b = 0; b < MAX_BW; b++) begin
        if (b < bw) begin
          bits[i*bw + b] = mask[i];
        end
      end
    end
    return bits;
  endfunction

endpackage

// File: rtl/proposal_sram_clr_ctrl.sv
// Clear engine: walks every row once, one per cycle, and reports busy while doing so.
module proposal_sram_clr_ctrl
  import proposal_sram_pkg::*;
#(
  parameter int ADDR_SPACE = ADDR_SPACE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_start,
  output logic                  busy,
  output logic [ADDR_SPACE-1:0] ptr
);

  localparam logic [ADDR_SPACE-1:0] LAST_ROW = {ADDR_SPACE{1'b1}};

  clr_state_e            state_r;
  logic [ADDR_SPACE-1:0] ptr_r;
  logic                  busy_r;

  // State, row pointer and busy flag; reset forces a fresh clear from row 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_CLEAR;
      ptr_r   <= '0;
      busy_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (clr_start) begin
            state_r <= ST_CLEAR;
            busy_r  <= 1'b1;
          end
          ptr_r <= '0;
        end
        ST_CLEAR: begin
          ptr_r <= ptr_r + {{(ADDR_SPACE-1){1'b0}}, 1'b1};
          if (ptr_r == LAST_ROW) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          ptr_r   <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign ptr  = ptr_r;

endmodule

// File: rtl/proposal_sram_param.sv
// Byte-maskable single-clock SRAM with registered read and a self-clearing engine.
// Define PROPOSAL_SRAM_BYPASS_EN for write-first same-address reads; default is read-first.
module proposal_sram_param
  import proposal_sram_pkg::*;
#(
  parameter int BW         = BW_DEF,
  parameter int Q          = Q_DEF,
  parameter int ADDR_SPACE = ADDR_SPACE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wsb,
  input  logic [BW*Q-1:0]       wdata,
  input  logic [Q-1:0]          bytemask,
  input  logic [ADDR_SPACE-1:0] waddr,
  input  logic                  ren,
  input  logic [ADDR_SPACE-1:0] raddr,
  input  logic                  clr_start,
  output logic [BW*Q-1:0]       rdata,
  output logic                  rvalid,
  output logic                  busy
);

  localparam int W     = BW * Q;
  localparam int DEPTH = 2 ** ADDR_SPACE;

  logic [W-1:0]          mem_r [DEPTH];
  logic [W-1:0]          rdata_r;
  logic                  rvalid_r;
  logic                  busy_s;
  logic [ADDR_SPACE-1:0] clr_ptr_s;
  logic [MAX_Q-1:0]      mask_ext_s;
  logic [W-1:0]          bitmask_s;
  logic [W-1:0]          merged_s;
  logic [W-1:0]          rd_word_s;
  logic                  wr_acc_s;
  logic                  rd_acc_s;

  proposal_sram_clr_ctrl #(
    .ADDR_SPACE (ADDR_SPACE)
  ) u_clr_ctrl (
    .clk       (clk),
    .rst       (rst),
    .clr_start (clr_start),
    .busy      (busy_s),
    .ptr       (clr_ptr_s)
  );

  assign wr_acc_s   = ~wsb & ~busy_s;
  assign rd_acc_s   = ren & ~busy_s;
  assign mask_ext_s = MAX_Q'(bytemask);
  assign bitmask_s  = W'(expand_mask(mask_ext_s, BW));
  assign merged_s   = (wdata & ~bitmask_s) | (mem_r[waddr] & bitmask_s);

  // Read source; the forwarding variant returns the word being written this edge.
  always_comb begin
    rd_word_s = mem_r[raddr];
`ifdef PROPOSAL_SRAM_BYPASS_EN
    if (wr_acc_s && (waddr == raddr)) begin
      rd_word_s = merged_s;
    end else begin
      rd_word_s = mem_r[raddr];
    end
`endif
  end

  // Storage: the clear engine owns the array while busy, external writes are dropped.
  always_ff @(posedge clk) begin
    if (busy_s) begin
      mem_r[clr_ptr_s] <= '0;
    end else if (wr_acc_s) begin
      mem_r[waddr] <= merged_s;
    end
  end

  // Read register: rdata holds between accepted reads, rvalid pulses per read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r  <= '0;
      rvalid_r <= 1'b0;
    end else if (rd_acc_s) begin
      rdata_r  <= rd_word_s;
      rvalid_r <= 1'b1;
    end else begin
      rvalid_r <= 1'b0;
    end
  end

  assign rdata  = rdata_r;
  assign rvalid = rvalid_r;
  assign busy   = busy_s;

endmodule

// File: tb/tb_proposal_sram_param.sv
// Scoreboard bench for proposal_sram_param at BW=8, Q=16, ADDR_SPACE=4.
module tb_proposal_sram_param;

  localparam int BW    = 8;
  localparam int Q     = 16;
  localparam int AS    = 4;
  localparam int W     = BW * Q;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          wsb;
  logic [W-1:0]  wdata;
  logic [Q-1:0]  bytemask;
  logic [AS-1:0] waddr;
  logic          ren;
  logic [AS-1:0] raddr;
  logic          clr_start;
  logic [W-1:0]  rdata;
  logic          rvalid;
  logic          busy;

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  proposal_sram_param #(.BW(BW), .Q(Q), .ADDR_SPACE(AS)) dut (
    .clk       (clk),
    .rst       (rst),
    .wsb       (wsb),
    .wdata     (wdata),
    .bytemask  (bytemask),
    .waddr     (waddr),
    .ren       (ren),
    .raddr     (raddr),
    .clr_start (clr_start),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] data);
    exp_t e;
    e.data = data;
    e.due  = cyc + 1;
    sb_q.push_back(e);
  endtask

  task automatic wr(input logic [AS-1:0] a, input logic [W-1:0] d, input logic [Q-1:0] m);
    waddr = a; wdata = d; bytemask = m; wsb = 1'b0;
    tick();
    wsb = 1'b1;
  endtask

  task automatic rd(input logic [AS-1:0] a, input logic [W-1:0] exp);
    raddr = a; ren = 1'b1;
    push_exp(exp);
    tick();
    ren = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
  endtask

  // Monitor: every rvalid must match the oldest expected word and arrive on its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rvalid === 1'b1) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL rvalid_unexpected: got rvalid=1 rdata=%h at cycle %0d, required no response", rdata, cyc);
      end else begin
        e = sb_q.pop_front();
        if (rdata !== e.data || cyc != e.due) begin
          miscompares++;
          $display("FAIL read_data: got %h at cycle %0d, required %h at cycle %0d", rdata, cyc, e.data, e.due);
        end
      end
    end else if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
      e = sb_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL read_missing: got no rvalid by cycle %0d, required %h at cycle %0d", cyc, e.data, e.due);
    end
  end

  initial begin
    int n;
    rst = 1'b1; wsb = 1'b1; ren = 1'b0; clr_start = 1'b0;
    wdata = '0; bytemask = '0; waddr = '0; raddr = '0;

    // Reset clear
    tick(); tick();
    chk("rst_busy", W'(busy), W'(1'b1));
    chk("rst_rvalid", W'(rvalid), W'(1'b0));
    chk("rst_rdata", rdata, '0);
    rst = 1'b0;
    count_busy(n);
    chk("reset_clear_len", W'(n), W'(16));
    for (int i = 0; i < DEPTH; i++) rd(AS'(i), '0);

    // Byte-masked write
    wr(4'd3, {16{8'h11}}, 16'h0000);
    wr(4'd3, {16{8'hFF}}, 16'hFF00);
    rd(4'd3, 128'h1111_1111_1111_1111_FFFF_FFFF_FFFF_FFFF);

    // Read and write to different addresses on one edge
    waddr = 4'd7; wdata = {16{8'h77}}; bytemask = 16'h0000; wsb = 1'b0;
    raddr = 4'd3; ren = 1'b1;
    push_exp(128'h1111_1111_1111_1111_FFFF_FFFF_FFFF_FFFF);
    tick();
    wsb = 1'b1; ren = 1'b0;
    rd(4'd7, {16{8'h77}});

    // Same-address collision
    wr(4'd5, {16{8'hAA}}, 16'h0000);
    waddr = 4'd5; wdata = {16{8'h55}}; bytemask = 16'h0000; wsb = 1'b0;
    raddr = 4'd5; ren = 1'b1;
`ifdef PROPOSAL_SRAM_BYPASS_EN
    push_exp({16{8'h55}});
`else
    push_exp({16{8'hAA}});
`endif
    tick();
    wsb = 1'b1; ren = 1'b0;
    rd(4'd5, {16{8'h55}});

    // Clear during traffic: start at cycle 0, write at 4, restart attempt at 6, read at 8
    wr(4'd2, {16{8'h22}}, 16'h0000);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      if (c == 4) begin
        waddr = 4'd2; wdata = {16{8'hEE}}; bytemask = 16'h0000; wsb = 1'b0;
      end
      if (c == 6) clr_start = 1'b1;
      if (c == 8) begin
        raddr = 4'd7; ren = 1'b1;
      end
      chk($sformatf("busy_c%0d", c), W'(busy), W'(c <= 16));
      tick();
      wsb = 1'b1; clr_start = 1'b0;
      if (c == 8) begin
        ren = 1'b0;
        chk("rvalid_while_busy", W'(rvalid), W'(1'b0));
      end
    end
    rd(4'd2, '0);
    rd(4'd7, '0);

    // Reset at clear row 9
    for (int i = 0; i < DEPTH; i++) wr(AS'(i), {16{8'(i + 1)}}, 16'h0000);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (9) tick();
    chk("midclear_busy", W'(busy), W'(1'b1));
    rst = 1'b1;
    tick(); tick();
    chk("midclear_rst_busy", W'(busy), W'(1'b1));
    chk("midclear_rst_rvalid", W'(rvalid), W'(1'b0));
    rst = 1'b0;
    count_busy(n);
    chk("midclear_clear_len", W'(n), W'(16));
    for (int i = 0; i < DEPTH; i++) rd(AS'(i), '0);

    repeat (3) tick();
    chk("scoreboard_drained", W'(sb_q.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/proposal_sram_param.md
PROPOSAL_SRAM_PARAM -- requirements
Module: proposal_sram_param

Interface
REQ-001 Parameter BW, default 8: bits per byte lane.
REQ-002 Parameter Q, default 16: byte lanes per word; word width is BW*Q.
REQ-003 Parameter ADDR_SPACE, default 4: address width; DEPTH = 2**ADDR_SPACE words.
REQ-004 Port clk, input, 1: single clock; all logic samples on the rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port wsb, input, 1: write strobe, active-low.
REQ-007 Port wdata, input, BW*Q: write data.
REQ-008 Port bytemask, input, Q: per-lane write mask; 1 = lane preserved, 0 = lane written.
REQ-009 Port waddr, input, ADDR_SPACE: write address.
REQ-010 Port ren, input, 1: read request, active-high.
REQ-011 Port raddr, input, ADDR_SPACE: read address.
REQ-012 Port clr_start, input, 1: single-cycle pulse that starts a full-array clear.
REQ-013 Port rdata, output, BW*Q: registered read data.
REQ-014 Port rvalid, output, 1: rdata was updated by the read accepted on the previous cycle.
REQ-015 Port busy, output, 1: clear engine active.

Function
REQ-016 Write path: a write is accepted on an edge where wsb=0 and busy=0.
REQ-017 Write result: mem[waddr] <= (wdata & ~bitmask) | (mem[waddr] & bitmask), where bitmask expands each bytemask bit to BW bits.
REQ-018 Read path: a read is accepted on an edge where ren=1 and busy=0; rdata gets mem[raddr] and rvalid=1 on that edge (latency 1 cycle).
REQ-019 Read hold: when no read is accepted, rvalid=0 and rdata holds its previous value.
REQ-020 Clear FSM states: IDLE and CLEAR.
- IDLE->CLEAR: on clr_start=1 while busy=0.
- CLEAR: writes all-zero to row ptr, then ptr increments (one row per cycle).
- CLEAR->IDLE: after row DEPTH-1 is written; ptr wraps to 0.
REQ-021 busy=1 exactly while the state is CLEAR, so a clear lasts DEPTH cycles.
REQ-022 clr_start asserted while busy is ignored; the clear is not restarted or extended.
REQ-023 During CLEAR, external writes are dropped (not queued), ren is ignored and rvalid stays 0.
REQ-024 A read and a write to different addresses on the same edge are independent.
REQ-025 Same-address read and write on the same edge: behaviour is defined by REQ-031/REQ-032.
REQ-026 The address path has no out-of-range case (DEPTH is a power of two).

Reset
REQ-027 While rst=1, on every edge: state=CLEAR, ptr=0, rdata=0, rvalid=0, busy=1.
REQ-028 After rst deasserts, the clear runs rows 0..DEPTH-1; busy falls after DEPTH edges and the whole array reads zero.
REQ-029 rst asserted mid-clear or mid-operation restarts the clear from row 0; contents of rows not yet cleared are unspecified until the clear completes.

Configuration
REQ-030 Macro PROPOSAL_SRAM_BYPASS_EN selects same-address read-during-write behaviour.
REQ-031 With PROPOSAL_SRAM_BYPASS_EN defined: a same-edge read of the address being written returns the merged new word (write-first forwarding).
REQ-032 Without PROPOSAL_SRAM_BYPASS_EN: a same-edge read of the address being written returns the pre-write contents (read-first).

Structure
REQ-033 Package proposal_sram_pkg holds the default BW, Q and ADDR_SPACE constants, the clear FSM state enum, and the bytemask-to-bitmask expansion function.
REQ-034 One sub-module, proposal_sram_clr_ctrl, contains the FSM, ptr and busy; the top module contains the storage, the merge logic and the read register.

Verification (BW=8, Q=16, ADDR_SPACE=4)
REQ-035 Reset clear:
- Stimulus: rst high 2 cycles, then low.
- Response: busy high for exactly 16 cycles after release; reading rows 0..15 afterwards returns 0 with rvalid=1 one cycle after each ren.
REQ-036 Byte-masked write:
- Stimulus: write addr 3 with all-0x11; then write addr 3 with all-0xFF and bytemask=16'hFF00.
- Response: reading addr 3 returns 0x1111...11FFFFFFFFFFFFFFFF (lanes 15..8 = 0x11, lanes 7..0 = 0xFF).
REQ-037 Collision:
- Stimulus: mem[5]=0xAA..AA; write 0x55..55 to addr 5 with bytemask=0 while reading addr 5 on the same edge.
- Response: rdata=0x55..55 with the BYPASS macro, 0xAA..AA without it; a read on the next cycle returns 0x55..55 in both builds.
REQ-038 Clear during traffic:
- Stimulus: clr_start at cycle 0, a write to addr 2 at cycle 4, a second clr_start at cycle 6.
- Response: busy high for cycles 1..16 only; addr 2 reads 0 afterwards; rvalid stays 0 for a ren issued while busy.
REQ-039 Reset mid-clear:
- Stimulus: assert rst at clear row 9.
- Response: after release, ptr restarts at 0, busy is high for a full 16 cycles, and all rows read 0.
